// File: rtl/branch_cond_unit.sv
// Branch condition unit: latches a 3-bit condition from the IR, evaluates it against the bus
// operand on request, and keeps saturating statistics of evaluations and taken branches.
module branch_cond_unit #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IR_W     = 32,
    parameter int unsigned COND_LSB = 19,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              ir_in,
    input  logic [IR_W-1:0]   ir_bus,
    input  logic              con_in,
    input  logic [DATA_W-1:0] bus_mux_out,
    output logic              con_ff_out,
    output logic              con_valid,
    output logic              branch_taken,
    output logic              con_err,
    output logic [CNT_W-1:0]  eval_count,
    output logic [CNT_W-1:0]  taken_count
);

    typedef enum logic [1:0] {StIdle, StArmed, StResolved} state_e;

    state_e             state_q, state_d;
    logic [2:0]         cond_q, cond_d;
    logic               con_ff_q, con_ff_d;
    logic               con_valid_q, con_valid_d;
    logic               taken_q, taken_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   eval_cnt_q, eval_cnt_d;
    logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;

    logic               bus_zero, bus_neg, cond_true, eval;
    logic               unused_ir_bits;

    assign unused_ir_bits = ^ir_bus;
    assign bus_zero = ~|bus_mux_out;
    assign bus_neg  = bus_mux_out[DATA_W-1];

    always_comb begin
        cond_true = 1'b0;
        case (cond_q)
            3'b000:  cond_true = bus_zero;
            3'b001:  cond_true = ~bus_zero;
            3'b010:  cond_true = ~bus_neg;
            3'b011:  cond_true = bus_neg;
            3'b100:  cond_true = ~bus_neg & ~bus_zero;
            3'b101:  cond_true = bus_neg | bus_zero;
            3'b110:  cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // Evaluation always uses the condition latched before this edge, even if ir_in is also high.
    assign eval = con_in && (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        cond_d      = cond_q;
        con_ff_d    = con_ff_q;
        con_valid_d = con_valid_q;
        taken_d     = 1'b0;
        err_d       = err_q;
        eval_cnt_d  = eval_cnt_q;
        taken_cnt_d = taken_cnt_q;

        if (eval) begin
            con_ff_d    = cond_true;
            taken_d     = cond_true;
            con_valid_d = 1'b1;
            state_d     = StResolved;
            if (eval_cnt_q != {CNT_W{1'b1}}) eval_cnt_d = eval_cnt_q + CNT_W'(1);
            if (cond_true && (taken_cnt_q != {CNT_W{1'b1}})) begin
                taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
        end

        if (ir_in) begin
            cond_d      = ir_bus[COND_LSB +: 3];
            state_d     = StArmed;
            con_valid_d = 1'b0;
        end else if (con_in && (state_q == StIdle)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q     <= StIdle;
            cond_q      <= 3'b000;
            con_ff_q    <= 1'b0;
            con_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            err_q       <= 1'b0;
            eval_cnt_q  <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cond_q      <= cond_d;
            con_ff_q    <= con_ff_d;
            con_valid_q <= con_valid_d;
            taken_q     <= taken_d;
            err_q       <= err_d;
            eval_cnt_q  <= eval_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign con_ff_out   = con_ff_q;
    assign con_valid    = con_valid_q;
    assign branch_taken = taken_q;
    assign con_err      = err_q;
    assign eval_count   = eval_cnt_q;
    assign taken_count  = taken_cnt_q;

endmodule

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 Parameter DATA_W, default 32, width of the bus operand being tested.
REQ-002 Parameter IR_W, default 32, instruction register width.
REQ-003 Parameter COND_LSB, default 19, LSB of the 3-bit condition field in the IR (bits COND_LSB+2:COND_LSB).
REQ-004 Parameter CNT_W, default 16, width of the statistics counters.
REQ-005 Port clock, input, 1, single system clock, rising-edge active.
REQ-006 Port clear, input, 1, reset, asynchronous and active-high.
REQ-007 Port ir_in, input, 1, IR-load strobe; latches the condition field from ir_bus.
REQ-008 Port ir_bus, input, IR_W, instruction word.
REQ-009 Port con_in, input, 1, evaluate strobe; sampled every rising edge.
REQ-010 Port bus_mux_out, input, DATA_W, operand under test.
REQ-011 Port con_ff_out, output, 1, registered branch decision.
REQ-012 Port con_valid, output, 1, high while con_ff_out holds a result for the currently latched condition.
REQ-013 Port branch_taken, output, 1, one-cycle pulse when an evaluation yields 1.
REQ-014 Port con_err, output, 1, sticky flag: con_in seen with no condition latched.
REQ-015 Port eval_count, output, CNT_W, number of evaluations performed.
REQ-016 Port taken_count, output, CNT_W, number of evaluations yielding 1.

Function
REQ-017 Condition codes SHALL be: 000 zero (bus==0); 001 nonzero; 010 ge (bus MSB==0); 011 lt (MSB==1); 100 gt (MSB==0 and bus!=0); 101 le (MSB==1 or bus==0); 110 always; 111 never. Codes 000-011 match the existing 2-bit encoding.
REQ-018 Sign SHALL be bit DATA_W-1 of bus_mux_out (two's complement). Zero test is a reduction NOR over all DATA_W bits.
REQ-019 FSM states SHALL be IDLE, ARMED and RESOLVED.
REQ-020 In any state, ir_in high SHALL latch the condition field into cond_reg and enter ARMED.
REQ-021 In ARMED or RESOLVED, con_in high without ir_in SHALL evaluate cond_reg against bus_mux_out and enter RESOLVED.
REQ-022 Evaluation latency SHALL be one cycle. con_ff_out, con_valid=1 and branch_taken appear on the edge that samples con_in.
REQ-023 branch_taken SHALL be high for exactly one cycle per evaluation yielding 1. It is 0 otherwise, including repeat evaluations that yield 0.
REQ-024 con_ff_out SHALL hold its last evaluated value until the next evaluation or reset. ir_in does not change it.
REQ-025 con_valid SHALL clear on the edge that samples ir_in and set on each evaluation.
REQ-026 ir_in and con_in high together in ARMED or RESOLVED: evaluation SHALL use the old cond_reg, the new field is latched, the state becomes ARMED, and con_valid=0.
REQ-027 ir_in and con_in high together in IDLE: the field is latched, the state becomes ARMED, there is no evaluation, and con_err is unchanged.
REQ-028 con_in high in IDLE without ir_in SHALL set con_err, change no other state, and count nothing.
REQ-029 Each cycle con_in is sampled high in ARMED or RESOLVED SHALL count as one evaluation. Back-to-back strobes re-evaluate every cycle.
REQ-030 eval_count SHALL increment per evaluation. taken_count SHALL increment per evaluation yielding 1. Both saturate at 2^CNT_W-1 with no wrap.
REQ-031 Condition codes 110 and 111 SHALL be counted like any other code.

Reset
REQ-032 clear high SHALL asynchronously force: state IDLE, cond_reg=000, con_ff_out=0, con_valid=0, branch_taken=0, con_err=0, eval_count=0, taken_count=0.
REQ-033 clear asserted mid-operation SHALL discard the latched condition. The first con_in after release without an ir_in sets con_err.
REQ-034 Outputs SHALL be driven only from registers. No combinational path exists from inputs to outputs.

Verification
REQ-035 Reset, then ir_bus bits[21:19]=000 with ir_in, then con_in with bus=0x00000000 -> next edge: con_ff_out=1, con_valid=1, branch_taken=1 for one cycle, eval_count=1, taken_count=1.
REQ-036 cond=011 (lt), con_in with bus=0x80000000 -> con_ff_out=1. con_in again with bus=0x00000005 -> con_ff_out=0, branch_taken=0, eval_count=2, taken_count=1.
REQ-037 cond=100 (gt): bus=0 -> 0; bus=0x00000001 -> 1; bus=0xFFFFFFFF -> 0. cond=101 (le) on the same three values -> 1, 0, 1.
REQ-038 con_in with no prior ir_in after reset -> con_err=1 and eval_count=0. Then ir_in plus con_in in the same cycle -> state ARMED, con_err stays 1, no evaluation.
REQ-039 cond=110 latched and RESOLVED. ir_in (new cond=111) and con_in together -> con_ff_out=1 from the old cond, con_valid=0. Next con_in -> con_ff_out=0.
REQ-040 CNT_W=4, cond=110, 20 consecutive con_in cycles -> eval_count=taken_count=15, holding. Assert clear asynchronously mid-burst -> all outputs 0 before the next clock edge.
